// File: rtl/sync_flag_arbiter_if.sv
// Event handshake between the flag arbiter (master) and its consumer (slave).
interface sync_flag_arbiter_if #(
   parameter int unsigned CH_W = 2
);
   logic            EVT_VALID;
   logic [CH_W-1:0] EVT_CH;
   logic            EVT_READY;

   modport master (output EVT_VALID, output EVT_CH, input EVT_READY);
   modport slave  (input EVT_VALID, input EVT_CH, output EVT_READY);
endinterface

// File: rtl/sync_flag_arbiter.sv
// Synchronises N_CH asynchronous level flags, turns rising edges into pending
// events and presents them one at a time with round-robin arbitration.
module sync_flag_arbiter #(
   parameter int unsigned N_CH = 4,
   parameter int unsigned CH_W = 2
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [N_CH-1:0]     FLAG_IN,
   input  logic [N_CH-1:0]     EN,
   sync_flag_arbiter_if.master evt,
   output logic [N_CH-1:0]     OVERFLOW,
   input  logic [N_CH-1:0]     CLR_OVF
);

   localparam int unsigned ARM_CYC = 4;
   localparam int unsigned ARM_W   = $clog2(ARM_CYC);

   typedef enum logic {IDLE, PRESENT} state_t;

   logic [N_CH-1:0]  s1, s2, s3, prev;
   logic [ARM_W-1:0] arm_cnt;
   logic             armed;
   logic [N_CH-1:0]  pending;
   logic [N_CH-1:0]  rise;
   logic [N_CH-1:0]  grant_vec;
   logic [N_CH-1:0]  pend_nxt;
   logic [N_CH-1:0]  ovf_nxt;
   logic [CH_W-1:0]  grant_idx;
   logic [CH_W-1:0]  last_grant;
   logic             grant_en;
   state_t           state;

   // First requesting channel strictly after 'last', wrapping at N_CH-1.
   function automatic logic [CH_W-1:0] rr_pick(input logic [N_CH-1:0] req,
                                                input logic [CH_W-1:0] last);
      logic [CH_W-1:0] pick;
      logic [CH_W-1:0] idx_c;
      logic            found;
      int unsigned     idx;
      pick  = '0;
      found = 1'b0;
      for (int unsigned k = 1; k <= N_CH; k++) begin
         idx   = (32'(last) + k) % N_CH;
         idx_c = CH_W'(idx);
         if (!found && req[idx_c]) begin
            pick  = idx_c;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   // Three-flop synchroniser, edge history and post-reset arming delay.
   always_ff @(posedge CLK) begin
      if (RST) begin
         s1      <= '0;
         s2      <= '0;
         s3      <= '0;
         prev    <= '0;
         arm_cnt <= '0;
         armed   <= 1'b0;
      end else begin
         s1   <= FLAG_IN;
         s2   <= s1;
         s3   <= s2;
         prev <= s3;
         if (!armed) begin
            arm_cnt <= arm_cnt + ARM_W'(1);
            armed   <= (arm_cnt == ARM_W'(ARM_CYC - 1));
         end
      end
   end

   always_comb begin
      rise      = s3 & ~prev & EN & {N_CH{armed}};
      grant_en  = (state == IDLE) && (|pending);
      grant_idx = rr_pick(pending, last_grant);
      grant_vec = grant_en ? (N_CH'(1) << grant_idx) : '0;
      // A rise coinciding with its own grant re-arms the channel instead of overflowing.
      pend_nxt  = (pending | rise) & ~(grant_vec & ~rise) & EN;
      ovf_nxt   = (OVERFLOW & ~CLR_OVF) | (rise & pending & ~grant_vec);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         pending  <= '0;
         OVERFLOW <= '0;
      end else begin
         pending  <= pend_nxt;
         OVERFLOW <= ovf_nxt;
      end
   end

   // Presentation FSM: grant from IDLE, hold the event until accepted.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state         <= IDLE;
         evt.EVT_VALID <= 1'b0;
         evt.EVT_CH    <= '0;
         last_grant    <= CH_W'(N_CH - 1);
      end else begin
         case (state)
            IDLE: begin
               if (grant_en) begin
                  state         <= PRESENT;
                  evt.EVT_VALID <= 1'b1;
                  evt.EVT_CH    <= grant_idx;
                  last_grant    <= grant_idx;
               end
            end
            PRESENT: begin
               if (evt.EVT_READY) begin
                  state         <= IDLE;
                  evt.EVT_VALID <= 1'b0;
               end
            end
            default: begin
               state         <= IDLE;
               evt.EVT_VALID <= 1'b0;
            end
         endcase
      end
   end

endmodule
